// File: rtl/alu_pkg.sv
// Shared opcode encodings, decoded control and flag bundles for the ALU pipeline.
package alu_pkg;

    localparam int unsigned OpWidth = 4;

    typedef enum logic [OpWidth-1:0] {
        OpAnd  = 4'b0000,
        OpOr   = 4'b0001,
        OpAdd  = 4'b0010,
        OpSub  = 4'b0011,
        OpSlt  = 4'b0100,
        OpSltu = 4'b0101,
        OpSrl  = 4'b0110,
        OpSll  = 4'b0111,
        OpSra  = 4'b1000,
        OpXor  = 4'b1001,
        OpNor  = 4'b1010
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    illegal;
    } alu_ctrl_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic illegal;
    } alu_flags_t;

    // Legal encodings are contiguous from OpAnd to OpNor; anything above is illegal.
    function automatic alu_ctrl_t alu_decode(input logic [63:0] opcode);
        alu_ctrl_t ctrl;
        ctrl.op      = OpAnd;
        ctrl.illegal = 1'b1;
        if (opcode <= 64'(OpNor)) begin
            ctrl.op      = alu_op_e'(opcode[OpWidth-1:0]);
            ctrl.illegal = 1'b0;
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: arithmetic, logic, shifter and result flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  alu_ctrl_t    ctrl_i,
    output logic [N-1:0] result_o,
    output alu_flags_t   flags_o
);

    localparam int unsigned ShW = $clog2(N);

    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [ShW-1:0] shamt;
    logic           add_ovf;
    logic           sub_ovf;

    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    // Carry out of A + ~B + 1 is the unsigned no-borrow indication.
    assign diff  = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};
    assign shamt = b_i[ShW-1:0];

    assign add_ovf = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
    assign sub_ovf = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);

    always_comb begin
        result_o = '0;
        flags_o  = '0;
        unique case (ctrl_i.op)
            OpAnd:  result_o = a_i & b_i;
            OpOr:   result_o = a_i | b_i;
            OpAdd: begin
                result_o      = sum[N-1:0];
                flags_o.carry = sum[N];
                flags_o.ovf   = add_ovf;
            end
            OpSub: begin
                result_o      = diff[N-1:0];
                flags_o.carry = diff[N];
                flags_o.ovf   = sub_ovf;
            end
            OpSlt:  result_o = {{(N-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OpSltu: result_o = {{(N-1){1'b0}}, a_i < b_i};
            OpSrl:  result_o = a_i >> shamt;
            OpSll:  result_o = a_i << shamt;
            OpSra:  result_o = $signed(a_i) >>> shamt;
            OpXor:  result_o = a_i ^ b_i;
            OpNor:  result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase

        // Illegal beats carry only the illegal flag, even though the result is zero.
        if (ctrl_i.illegal) begin
            result_o        = '0;
            flags_o         = '0;
            flags_o.illegal = 1'b1;
        end else begin
            flags_o.zero = (result_o == '0);
            flags_o.neg  = result_o[N-1];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operands+control in stage 1, result+flags in stage 2.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned OPW = OpWidth
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic [OPW-1:0] operacion_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [N-1:0]   resultado_o,
    output logic           c_o,
    output logic           zeroflag_o,
    output logic           neg_o,
    output logic           ovf_o,
    output logic           illegal_o
);

    logic       s1_valid_q, s1_valid_d;
    logic [N-1:0] s1_a_q, s1_a_d;
    logic [N-1:0] s1_b_q, s1_b_d;
    alu_ctrl_t  s1_ctrl_q, s1_ctrl_d;

    logic       s2_valid_q, s2_valid_d;
    logic [N-1:0] s2_result_q, s2_result_d;
    alu_flags_t s2_flags_q, s2_flags_d;

    logic       s2_advance;
    logic       in_accept;
    alu_ctrl_t  in_ctrl;
    logic [N-1:0] core_result;
    alu_flags_t core_flags;

    assign in_ctrl    = alu_decode(64'(operacion_i));
    assign s2_advance = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s2_advance;
    assign in_accept  = in_valid_i && in_ready_o;

    alu_core #(
        .N(N)
    ) u_core (
        .a_i     (s1_a_q),
        .b_i     (s1_b_q),
        .ctrl_i  (s1_ctrl_q),
        .result_o(core_result),
        .flags_o (core_flags)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ctrl_d  = s1_ctrl_q;
        if (in_ready_o) begin
            s1_valid_d = in_valid_i;
        end
        if (in_accept) begin
            s1_a_d    = a_i;
            s1_b_d    = b_i;
            s1_ctrl_d = in_ctrl;
        end
    end

    // Stage 2 only changes when its beat leaves (or it is empty), keeping outputs stable.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_flags_d  = core_flags;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_ctrl_q   <= '{op: OpAnd, illegal: 1'b0};
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign resultado_o = s2_result_q;
    assign c_o         = s2_flags_q.carry;
    assign zeroflag_o  = s2_flags_q.zero;
    assign neg_o       = s2_flags_q.neg;
    assign ovf_o       = s2_flags_q.ovf;
    assign illegal_o   = s2_flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at N=8: directed vector table, stream/backpressure/reset sequences, random traffic.
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        exp_t       e;
    } vec_t;

    typedef struct {
        exp_t e;
        int   acc_edge;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [3:0] op_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] res;
    logic       c_f, z_f, n_f, v_f, ill_f;

    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    sb_t  sb[$];
    bit   held = 0;
    exp_t prev_got;
    vec_t tbl[16];

    always #5 clk = ~clk;

    alu_pipe #(
        .N  (8),
        .OPW(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a_in),
        .b_i        (b_in),
        .operacion_i(op_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .resultado_o(res),
        .c_o        (c_f),
        .zeroflag_o (z_f),
        .neg_o      (n_f),
        .ovf_o      (v_f),
        .illegal_o  (ill_f)
    );

    // Reference: plain integer arithmetic on the opcode rules.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_t e;
        int ua, ub, sa, sbv, r, sh;
        e   = '0;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua >= 128) ? ua - 256 : ua;
        sbv = (ub >= 128) ? ub - 256 : ub;
        sh  = ub % 8;
        r   = 0;
        case (op)
            4'd0:  r = ua & ub;
            4'd1:  r = ua | ub;
            4'd2: begin
                r   = ua + ub;
                e.c = (r > 255);
                e.v = ((sa + sbv) > 127) || ((sa + sbv) < -128);
            end
            4'd3: begin
                r   = ua - ub;
                e.c = (ua >= ub);
                e.v = ((sa - sbv) > 127) || ((sa - sbv) < -128);
            end
            4'd4:  r = (sa < sbv) ? 1 : 0;
            4'd5:  r = (ua < ub) ? 1 : 0;
            4'd6:  r = ua >> sh;
            4'd7:  r = ua << sh;
            4'd8:  r = sa >>> sh;
            4'd9:  r = ua ^ ub;
            4'd10: r = ~(ua | ub);
            default: begin
                e.ill = 1'b1;
                return e;
            end
        endcase
        e.res = r[7:0];
        e.z   = (e.res == 8'h00);
        e.n   = e.res[7];
        return e;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    task automatic check_exp(input string name, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got res=%h c%b z%b n%b v%b ill%b expected res=%h c%b z%b n%b v%b ill%b",
                     name, got.res, got.c, got.z, got.n, got.v, got.ill,
                     exp.res, exp.c, exp.z, exp.n, exp.v, exp.ill);
        end
    endtask

    // One clock cycle: drive, check against the scoreboard, then account for the edge.
    // A beat is visible once at least one edge has passed since its acceptance and it is oldest.
    task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic ordy, input bit use_tab,
                        input exp_t tab);
        exp_t got;
        bit   exp_valid, exp_rdy, xfer, acc;
        sb_t  ent;
        @(negedge clk);
        in_valid  = iv;
        a_in      = a;
        b_in      = b;
        op_in     = op;
        out_ready = ordy;
        #1;
        exp_valid = (sb.size() > 0) && (sb[0].acc_edge < edge_cnt);
        exp_rdy   = (sb.size() < 2) || ordy;
        check_bit("out_valid", out_valid, exp_valid);
        check_bit("in_ready", in_ready, exp_rdy);
        got = {res, c_f, z_f, n_f, v_f, ill_f};
        if (exp_valid && out_valid) check_exp("result", got, sb[0].e);
        if (held && exp_valid) check_exp("stable", got, prev_got);
        xfer     = exp_valid && ordy;
        acc      = iv && exp_rdy;
        held     = exp_valid && !ordy;
        prev_got = got;
        @(posedge clk);
        edge_cnt++;
        if (xfer) void'(sb.pop_front());
        if (acc) begin
            ent.e        = use_tab ? tab : model(a, b, op);
            ent.acc_edge = edge_cnt;
            sb.push_back(ent);
        end
    endtask

    task automatic do_reset(input int cycles);
        exp_t got;
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            edge_cnt++;
        end
        sb.delete();
        held = 0;
        @(negedge clk);
        #1;
        got = {res, c_f, z_f, n_f, v_f, ill_f};
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_exp("rst_outputs", got, '0);
        rst = 1'b0;
        #1;
        check_bit("rst_in_ready", in_ready, 1'b1);
    endtask

    task automatic idle(input int cycles, input logic ordy);
        repeat (cycles) step(1'b0, 8'h00, 8'h00, 4'h0, ordy, 0, '0);
    endtask

    initial begin
        //               a      b      op       res    c     z     n     v     ill
        tbl[0]  = '{8'h7F, 8'h01, 4'h2, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[1]  = '{8'h05, 8'h05, 4'h3, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[2]  = '{8'h03, 8'h05, 4'h3, '{8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{8'hFF, 8'h01, 4'h4, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[4]  = '{8'hFF, 8'h01, 4'h5, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{8'h80, 8'h0B, 4'h8, '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[6]  = '{8'h12, 8'h34, 4'hF, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[7]  = '{8'hFF, 8'h01, 4'h2, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[8]  = '{8'h80, 8'h01, 4'h3, '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[9]  = '{8'hA5, 8'h08, 4'h7, '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[10] = '{8'hF0, 8'h04, 4'h6, '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[11] = '{8'h0F, 8'hF0, 4'hA, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[12] = '{8'hAA, 8'h55, 4'h9, '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[13] = '{8'hC3, 8'h0F, 4'h0, '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[14] = '{8'h00, 8'h00, 4'h1, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[15] = '{8'hFF, 8'hFF, 4'hB, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};

        do_reset(2);

        // Directed vectors, each isolated so the two-edge latency is observed.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1, 1, tbl[i].e);
            idle(2, 1'b1);
        end

        // Ten back-to-back beats with the consumer always ready.
        for (int i = 0; i < 10; i++)
            step(1'b1, 8'($urandom), 8'($urandom), 4'(i % 11), 1'b1, 0, '0);
        idle(3, 1'b1);

        // Stall the consumer for five cycles mid-stream, then release.
        for (int i = 0; i < 2; i++)
            step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)), 1'b1, 0, '0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)), 1'b0, 0, '0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)), 1'b1, 0, '0);
        idle(4, 1'b1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_after_stall: pending=%0d expected=0", sb.size());
        end

        // Reset with two beats in flight; nothing stale may emerge afterwards.
        step(1'b1, 8'h11, 8'h22, 4'h2, 1'b0, 0, '0);
        step(1'b1, 8'h33, 8'h44, 4'h3, 1'b0, 0, '0);
        do_reset(1);
        idle(4, 1'b1);

        // Random traffic including illegal opcodes and random backpressure.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 0, '0);
        idle(6, 1'b1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_final: pending=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
